reg_port_arbiter: RTL and testbench

REG_PORT_ARBITER -- requirements
Module: reg_port_arbiter

---
 rtl/reg_port_arbiter_pkg.sv | 19 +
 rtl/reg_port_arbiter_if.sv | 31 +++
 rtl/reg_port_arbiter_starve_counter.sv | 22 ++
 rtl/reg_port_arbiter.sv | 84 ++++++++
 tb/tb_reg_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_port_arbiter_pkg.sv
// Shared definitions for the register-file port arbiter: FSM encoding,
// the hard-wired zero register and the default starvation limit.
package reg_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOST_XFER = 2'd1,
    HOST_DONE = 2'd2
  } arb_state_t;

  localparam logic [4:0]  REG_ZERO             = 5'd0;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 8;

  // Register $0 is hard-wired, so any write aimed at it is dropped.
  function automatic logic write_allowed(input logic we, input logic [4:0] addr);
    return we && (addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/reg_port_arbiter_if.sv
// Bundle of core writeback, debug host and register-file port signals
// shared between the arbiter and its environment.
interface reg_port_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        core_stall;

  logic        host_req;
  logic        host_wr;
  logic [4:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic [31:0] host_rdata;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;

  modport slave (
    input  wb_we, wb_addr, wb_data, host_req, host_wr, host_addr, host_wdata, rf_rdata,
    output core_stall, host_ack, host_rdata, rf_we, rf_waddr, rf_wdata, rf_raddr
  );

  modport master (
    output wb_we, wb_addr, wb_data, host_req, host_wr, host_addr, host_wdata, rf_rdata,
    input  core_stall, host_ack, host_rdata, rf_we, rf_waddr, rf_wdata, rf_raddr
  );
endinterface

// File: rtl/reg_port_arbiter_starve_counter.sv
// Saturating count of denied host-request cycles; at_limit forces the
// next host grant over a busy core writeback.
module starve_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  input  logic [3:0] limit,
  output logic       at_limit
);
  logic [3:0] count;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != limit)) begin
      count <= count + 4'd1;
    end
  end

  assign at_limit = (count == limit);
endmodule

// File: rtl/reg_port_arbiter.sv
// Arbitrates the single register-file write/read port between core
// writeback and a debug host peek/poke channel.
module reg_port_arbiter
  import reg_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  reg_port_arbiter_if.slave  bus
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t state;
  logic       grant;
  logic       cnt_inc;
  logic       cnt_clr;
  logic       at_limit;
  logic       mux_we;

  // A forced grant still lets this cycle's core write through.
  always_comb begin
    grant   = (state == IDLE) && bus.host_req && (!bus.wb_we || at_limit);
    cnt_inc = (state == IDLE) && bus.host_req && bus.wb_we && !grant;
    cnt_clr = grant || ((state == IDLE) && !bus.host_req);
  end

  starve_counter u_starve (
    .clock    (clock),
    .reset    (reset),
    .inc      (cnt_inc),
    .clr      (cnt_clr),
    .limit    (LIMIT),
    .at_limit (at_limit)
  );

  always_comb begin
    mux_we       = bus.wb_we;
    bus.rf_waddr = bus.wb_addr;
    bus.rf_wdata = bus.wb_data;
    bus.rf_raddr = bus.host_addr;
    if (state == HOST_XFER) begin
      mux_we       = bus.host_wr;
      bus.rf_waddr = bus.host_addr;
      bus.rf_wdata = bus.host_wdata;
    end
    bus.rf_we = !reset && write_allowed(mux_we, bus.rf_waddr);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      bus.core_stall <= 1'b0;
      bus.host_ack   <= 1'b0;
      bus.host_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state          <= HOST_XFER;
            bus.core_stall <= 1'b1;
          end
        end
        HOST_XFER: begin
          if (!bus.host_wr) begin
            bus.host_rdata <= bus.rf_rdata;
          end
          state          <= HOST_DONE;
          bus.core_stall <= 1'b0;
          bus.host_ack   <= 1'b1;
        end
        HOST_DONE: begin
          state        <= IDLE;
          bus.host_ack <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          bus.core_stall <= 1'b0;
          bus.host_ack   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reg_port_arbiter.sv
// Randomized bench for reg_port_arbiter: transaction-level reference model
// feeding expectation queues that a negedge monitor drains.
module tb_reg_port_arbiter;
  localparam int unsigned LIM = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  reg_port_arbiter_if bus();

  reg_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] fill_val(input int i);
    return (i == 5) ? 32'h1234_5678 : (32'hA5A5_0000 | 32'(i));
  endfunction

  // Register file behind the arbiter: async read, write on rising edge.
  logic [31:0] regs [32];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= fill_val(i);
    end else if (bus.rf_we) begin
      regs[bus.rf_waddr] <= bus.rf_wdata;
    end
  end
  assign bus.rf_rdata = regs[bus.rf_raddr];

  typedef struct {
    int          cyc;
    bit          stall;
    bit          we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    bit          rd0;
  } cyc_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
  } ack_exp_t;

  cyc_exp_t    cyc_q[$];
  ack_exp_t    ack_q[$];
  logic [31:0] shadow [32];
  logic [31:0] last_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clock) begin : monitor
    cyc_exp_t e;
    ack_exp_t a;
    if (cyc_q.size() > 0 && cyc_q[0].cyc == cyc) begin
      e = cyc_q.pop_front();
      check("core_stall", 32'(bus.core_stall), 32'(e.stall));
      check("rf_we", 32'(bus.rf_we), 32'(e.we));
      if (e.we) begin
        check("rf_waddr", 32'(bus.rf_waddr), 32'(e.waddr));
        check("rf_wdata", bus.rf_wdata, e.wdata);
      end
      if (e.rd0) begin
        check("host_rdata_reset", bus.host_rdata, 32'h0);
        check("host_ack_reset", 32'(bus.host_ack), 32'h0);
      end
    end
    if (bus.host_ack === 1'b1) begin
      if (ack_q.size() == 0) begin
        check("unexpected_ack", 32'(bus.host_ack), 32'h0);
      end else begin
        a = ack_q.pop_front();
        check("ack_cycle", 32'(cyc), 32'(a.cyc));
        check("host_rdata", bus.host_rdata, a.rdata);
      end
    end else if (ack_q.size() > 0 && ack_q[0].cyc <= cyc) begin
      a = ack_q.pop_front();
      check("missing_ack", 32'(bus.host_ack), 32'h1);
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic refill_shadow();
    for (int i = 0; i < 32; i++) shadow[i] = fill_val(i);
    last_rd = 32'h0;
  endtask

  task automatic drive_core_rand(input int pct);
    bus.wb_we   = ($urandom_range(99) < pct);
    bus.wb_addr = 5'($urandom_range(31));
    bus.wb_data = $urandom;
  endtask

  task automatic push_exp(input bit stall, input bit we, input logic [4:0] a,
                          input logic [31:0] d, input bit rd0);
    cyc_q.push_back('{cyc, stall, we, a, d, rd0});
  endtask

  // Core owns the port this cycle: its write lands unless aimed at $0.
  task automatic core_owned(input bit rd0);
    bit w;
    w = bus.wb_we && (bus.wb_addr != 5'd0);
    if (w) shadow[bus.wb_addr] = bus.wb_data;
    push_exp(1'b0, w, bus.wb_addr, bus.wb_data, rd0);
  endtask

  task automatic idle(input int pct);
    next_cycle();
    bus.host_req = 1'b0;
    drive_core_rand(pct);
    core_owned(1'b0);
  endtask

  task automatic core_write(input logic [4:0] a, input logic [31:0] d);
    next_cycle();
    bus.host_req = 1'b0;
    bus.wb_we    = 1'b1;
    bus.wb_addr  = a;
    bus.wb_data  = d;
    core_owned(1'b0);
  endtask

  // One host transaction: granted on the first request cycle with no core
  // write, or once LIM request cycles have been denied; stall next cycle,
  // ack the cycle after.
  task automatic txn(input bit wr, input logic [4:0] addr, input logic [31:0] wdata,
                     input int pct);
    int          denied;
    bit          granted;
    bit          hw;
    logic [31:0] exp_rd;
    denied  = 0;
    granted = 1'b0;
    while (!granted) begin
      next_cycle();
      bus.host_req   = 1'b1;
      bus.host_wr    = wr;
      bus.host_addr  = addr;
      bus.host_wdata = wdata;
      drive_core_rand(pct);
      core_owned(1'b0);
      if (!bus.wb_we || denied == int'(LIM)) granted = 1'b1;
      else denied++;
    end
    next_cycle();
    drive_core_rand(pct);
    hw     = wr && (addr != 5'd0);
    exp_rd = wr ? last_rd : shadow[addr];
    if (hw) shadow[addr] = wdata;
    last_rd = exp_rd;
    push_exp(1'b1, hw, addr, wdata, 1'b0);
    ack_q.push_back('{cyc + 1, exp_rd});
    next_cycle();
    drive_core_rand(pct);
    core_owned(1'b0);
  endtask

  initial begin
    bus.wb_we      = 1'b0;
    bus.wb_addr    = '0;
    bus.wb_data    = '0;
    bus.host_req   = 1'b0;
    bus.host_wr    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    last_rd        = '0;
    reset          = 1'b1;

    // Reset holds rf_we low even with a core write pending.
    next_cycle();
    bus.wb_we   = 1'b1;
    bus.wb_addr = 5'd3;
    bus.wb_data = 32'h0BAD_0BAD;
    push_exp(1'b0, 1'b0, 5'd3, 32'h0BAD_0BAD, 1'b1);
    next_cycle();
    reset = 1'b0;
    refill_shadow();
    bus.wb_we = 1'b0;
    core_owned(1'b1);

    txn(1'b0, 5'd5, 32'h0, 0);
    idle(0);
    txn(1'b1, 5'd7, 32'hDEAD_BEEF, 0);
    idle(0);
    txn(1'b0, 5'd7, 32'h0, 0);
    idle(0);

    idle(0);
    txn(1'b0, 5'd5, 32'h0, 100);
    idle(0);

    core_write(5'd0, 32'hFFFF_FFFF);
    txn(1'b1, 5'd0, 32'h5555_AAAA, 0);
    idle(0);
    txn(1'b0, 5'd0, 32'h0, 0);

    txn(1'b0, 5'd5, 32'h0, 0);
    txn(1'b1, 5'd9, 32'h0F0F_0F0F, 0);
    txn(1'b0, 5'd9, 32'h0, 0);
    idle(0);

    // Reset while the host owns the port: no ack, rdata cleared.
    next_cycle();
    bus.host_req   = 1'b1;
    bus.host_wr    = 1'b1;
    bus.host_addr  = 5'd9;
    bus.host_wdata = 32'hCAFE_F00D;
    bus.wb_we      = 1'b0;
    core_owned(1'b0);
    next_cycle();
    reset = 1'b1;
    drive_core_rand(50);
    push_exp(1'b1, 1'b0, 5'd9, 32'hCAFE_F00D, 1'b0);
    next_cycle();
    reset        = 1'b0;
    bus.host_req = 1'b0;
    refill_shadow();
    drive_core_rand(50);
    core_owned(1'b1);

    for (int t = 0; t < 200; t++) begin
      int p;
      int k;
      case ($urandom_range(3))
        0:       p = 0;
        1:       p = 30;
        2:       p = 70;
        default: p = 100;
      endcase
      txn(1'($urandom_range(1)), 5'($urandom_range(7)), $urandom, p);
      k = $urandom_range(3);
      for (int j = 0; j < k; j++) idle(p);
    end

    for (int j = 0; j < 4; j++) idle(0);
    @(negedge clock);
    for (int i = 0; i < 32; i++) check("regfile", regs[i], shadow[i]);
    check("pending_acks", 32'(ack_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
